// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main control FSM and the ALU control stage.
// Holds state codes, opcodes, datapath select encodings and the control-word layout.
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_FETCH     = 4'd1,
      ST_DECODE    = 4'd2,
      ST_MEM_ADDR  = 4'd3,
      ST_MEM_READ  = 4'd4,
      ST_MEM_WB    = 4'd5,
      ST_MEM_WRITE = 4'd6,
      ST_R_EXEC    = 4'd7,
      ST_R_WB      = 4'd8,
      ST_BRANCH    = 4'd9,
      ST_JUMP      = 4'd10,
      ST_ADDI_EXEC = 4'd11,
      ST_ADDI_WB   = 4'd12,
      ST_ILLEGAL   = 4'd13
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam logic [1:0] ALU_OP_ADD   = 2'b00;
   localparam logic [1:0] ALU_OP_SUB   = 2'b01;
   localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

   localparam logic [1:0] SRC_B_REG     = 2'b00;
   localparam logic [1:0] SRC_B_FOUR    = 2'b01;
   localparam logic [1:0] SRC_B_IMM     = 2'b10;
   localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

   localparam logic [1:0] PC_SRC_ALU    = 2'b00;
   localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
      logic       instr_done;
      logic       illegal;
   } ctrl_t;

   // First execution state for each supported opcode; anything else traps.
   function automatic state_e dispatch(input logic [5:0] op);
      case (op)
         OP_LW, OP_SW: return ST_MEM_ADDR;
         OP_RTYPE:     return ST_R_EXEC;
         OP_BEQ:       return ST_BRANCH;
         OP_J:         return ST_JUMP;
         OP_ADDI:      return ST_ADDI_EXEC;
         default:      return ST_ILLEGAL;
      endcase
   endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational state-to-control-word table for the MIPS main control FSM.
// Unused state codes fall through to an all-zero control word.
module mips_ctrl_decode
   import mips_ctrl_pkg::*;
(
   input  state_e state,
   output ctrl_t  ctrl
);

   always_comb begin
      ctrl = '0;
      case (state)
         ST_FETCH: begin
            ctrl.mem_read  = 1'b1;
            ctrl.ir_write  = 1'b1;
            ctrl.pc_write  = 1'b1;
            ctrl.alu_src_b = SRC_B_FOUR;
            ctrl.alu_op    = ALU_OP_ADD;
            ctrl.pc_source = PC_SRC_ALU;
         end
         ST_DECODE: begin
            ctrl.alu_src_b = SRC_B_IMM_SH2;
            ctrl.alu_op    = ALU_OP_ADD;
         end
         ST_MEM_ADDR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRC_B_IMM;
            ctrl.alu_op    = ALU_OP_ADD;
         end
         ST_MEM_READ: begin
            ctrl.mem_read = 1'b1;
            ctrl.i_or_d   = 1'b1;
         end
         ST_MEM_WB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b1;
            ctrl.instr_done = 1'b1;
         end
         ST_MEM_WRITE: begin
            ctrl.mem_write  = 1'b1;
            ctrl.i_or_d     = 1'b1;
            ctrl.instr_done = 1'b1;
         end
         ST_R_EXEC: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRC_B_REG;
            ctrl.alu_op    = ALU_OP_FUNCT;
         end
         ST_R_WB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.reg_dst    = 1'b1;
            ctrl.instr_done = 1'b1;
         end
         ST_BRANCH: begin
            ctrl.alu_src_a     = 1'b1;
            ctrl.alu_src_b     = SRC_B_REG;
            ctrl.alu_op        = ALU_OP_SUB;
            ctrl.pc_write_cond = 1'b1;
            ctrl.pc_source     = PC_SRC_ALUOUT;
            ctrl.instr_done    = 1'b1;
         end
         ST_JUMP: begin
            ctrl.pc_write   = 1'b1;
            ctrl.pc_source  = PC_SRC_JUMP;
            ctrl.instr_done = 1'b1;
         end
         ST_ADDI_EXEC: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRC_B_IMM;
            ctrl.alu_op    = ALU_OP_ADD;
         end
         ST_ADDI_WB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.instr_done = 1'b1;
         end
         ST_ILLEGAL: begin
            ctrl.illegal = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mips_main_control.sv
// Multicycle MIPS main control: state register, latched opcode and next-state logic.
// All outputs are a Moore function of the state, produced by mips_ctrl_decode.
module mips_main_control
   import mips_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       i_or_d,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       mem_to_reg,
   output logic       reg_dst,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] pc_source,
   output logic       instr_done,
   output logic       illegal,
   output logic [3:0] state
);

   state_e     state_q, state_d;
   logic [5:0] opcode_q, opcode_d;
   ctrl_t      ctrl;

   always_comb begin
      state_d  = state_q;
      opcode_d = opcode_q;
      case (state_q)
         ST_IDLE:      state_d = ST_FETCH;
         ST_FETCH:     state_d = ST_DECODE;
         ST_DECODE: begin
            opcode_d = opcode;
            state_d  = dispatch(opcode);
         end
         // Only lw and sw reach MEM_ADDR, so the latched opcode picks the direction.
         ST_MEM_ADDR:  state_d = (opcode_q == OP_LW) ? ST_MEM_READ : ST_MEM_WRITE;
         ST_MEM_READ:  state_d = ST_MEM_WB;
         ST_R_EXEC:    state_d = ST_R_WB;
         ST_ADDI_EXEC: state_d = ST_ADDI_WB;
         ST_MEM_WB, ST_MEM_WRITE, ST_R_WB,
         ST_BRANCH, ST_JUMP, ST_ADDI_WB:
                       state_d = ST_FETCH;
         ST_ILLEGAL:   state_d = ST_ILLEGAL;
         default:      state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         opcode_q <= '0;
      end else begin
         state_q  <= state_d;
         opcode_q <= opcode_d;
      end
   end

   mips_ctrl_decode u_decode (
      .state (state_q),
      .ctrl  (ctrl)
   );

   assign pc_write      = ctrl.pc_write;
   assign pc_write_cond = ctrl.pc_write_cond;
   assign i_or_d        = ctrl.i_or_d;
   assign mem_read      = ctrl.mem_read;
   assign mem_write     = ctrl.mem_write;
   assign ir_write      = ctrl.ir_write;
   assign mem_to_reg    = ctrl.mem_to_reg;
   assign reg_dst       = ctrl.reg_dst;
   assign reg_write     = ctrl.reg_write;
   assign alu_src_a     = ctrl.alu_src_a;
   assign alu_src_b     = ctrl.alu_src_b;
   assign alu_op        = ctrl.alu_op;
   assign pc_source     = ctrl.pc_source;
   assign instr_done    = ctrl.instr_done;
   assign illegal       = ctrl.illegal;
   assign state         = state_q;

endmodule

// File: tb/tb_mips_main_control.sv
// Directed self-checking bench for mips_main_control.
// Outputs are sampled on the falling clock edge, away from the active rising edge.
module tb_mips_main_control;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] opcode = 6'b0;
   logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
   logic       mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, illegal;
   logic [1:0] alu_src_b, alu_op, pc_source;
   logic [3:0] state;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   mips_main_control dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .opcode        (opcode),
      .pc_write      (pc_write),
      .pc_write_cond (pc_write_cond),
      .i_or_d        (i_or_d),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .ir_write      (ir_write),
      .mem_to_reg    (mem_to_reg),
      .reg_dst       (reg_dst),
      .reg_write     (reg_write),
      .alu_src_a     (alu_src_a),
      .alu_src_b     (alu_src_b),
      .alu_op        (alu_op),
      .pc_source     (pc_source),
      .instr_done    (instr_done),
      .illegal       (illegal),
      .state         (state)
   );

   always #5 clk = ~clk;

   logic [17:0] outs;
   assign outs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                  pc_source, instr_done, illegal};

   // Hand-written per-state output table, in the same field order as outs.
   function automatic logic [17:0] exp_outs(input logic [3:0] s);
      logic pw, pwc, iod, mr, mw, irw, m2r, rdst, rw, asa, done, ill;
      logic [1:0] asb, aop, pcs;
      {pw, pwc, iod, mr, mw, irw, m2r, rdst, rw, asa, done, ill} = '0;
      asb = 2'b00; aop = 2'b00; pcs = 2'b00;
      case (s)
         4'd1:  begin mr = 1; irw = 1; pw = 1; asb = 2'b01; end
         4'd2:  begin asb = 2'b11; end
         4'd3:  begin asa = 1; asb = 2'b10; end
         4'd4:  begin mr = 1; iod = 1; end
         4'd5:  begin rw = 1; m2r = 1; done = 1; end
         4'd6:  begin mw = 1; iod = 1; done = 1; end
         4'd7:  begin asa = 1; aop = 2'b10; end
         4'd8:  begin rw = 1; rdst = 1; done = 1; end
         4'd9:  begin asa = 1; aop = 2'b01; pwc = 1; pcs = 2'b01; done = 1; end
         4'd10: begin pw = 1; pcs = 2'b10; done = 1; end
         4'd11: begin asa = 1; asb = 2'b10; end
         4'd12: begin rw = 1; done = 1; end
         4'd13: begin ill = 1; end
         default: ;
      endcase
      return {pw, pwc, iod, mr, mw, irw, m2r, rdst, rw, asa, asb, aop, pcs, done, ill};
   endfunction

   task automatic test_reset();
      @(negedge clk);
      @(negedge clk);
      n_cmp++;
      if (state !== 4'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", state); end
      n_cmp++;
      if (outs !== 18'd0) begin n_bad++; $display("FAIL reset_outs: got %b want all 0", outs); end
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (state !== 4'd1) begin n_bad++; $display("FAIL reset_release_state: got %0d want 1", state); end
      n_cmp++;
      if ({mem_read, ir_write, pc_write} !== 3'b111)
         begin n_bad++; $display("FAIL reset_release_fetch: got %b want 111", {mem_read, ir_write, pc_write}); end
   endtask

   task automatic test_lw();
      logic [3:0] seq [6] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd1};
      int unsigned dones = 0;
      opcode = 6'b100011;
      for (int i = 0; i < 6; i++) begin
         if (i > 0) @(negedge clk);
         n_cmp++;
         if (state !== seq[i]) begin n_bad++; $display("FAIL lw_state[%0d]: got %0d want %0d", i, state, seq[i]); end
         n_cmp++;
         if (outs !== exp_outs(seq[i])) begin n_bad++; $display("FAIL lw_outs[%0d]: got %b want %b", i, outs, exp_outs(seq[i])); end
         if (i < 5 && instr_done === 1'b1) dones++;
      end
      n_cmp++;
      if (dones !== 1) begin n_bad++; $display("FAIL lw_done_count: got %0d want 1", dones); end
   endtask

   task automatic test_rtype();
      logic [3:0] seq [5] = '{4'd1, 4'd2, 4'd7, 4'd8, 4'd1};
      opcode = 6'b000000;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         n_cmp++;
         if (state !== seq[i]) begin n_bad++; $display("FAIL rtype_state[%0d]: got %0d want %0d", i, state, seq[i]); end
         n_cmp++;
         if (outs !== exp_outs(seq[i])) begin n_bad++; $display("FAIL rtype_outs[%0d]: got %b want %b", i, outs, exp_outs(seq[i])); end
         if (i == 2) begin
            n_cmp++;
            if (alu_op !== 2'b10) begin n_bad++; $display("FAIL rtype_alu_op: got %b want 10", alu_op); end
         end
         if (i == 3) begin
            n_cmp++;
            if ({reg_write, reg_dst} !== 2'b11) begin n_bad++; $display("FAIL rtype_wb: got %b want 11", {reg_write, reg_dst}); end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] seq [7] = '{4'd1, 4'd2, 4'd9, 4'd1, 4'd2, 4'd10, 4'd1};
      int unsigned dones = 0;
      opcode = 6'b000100;
      for (int i = 0; i < 7; i++) begin
         if (i > 0) @(negedge clk);
         if (i == 3) opcode = 6'b000010;
         n_cmp++;
         if (state !== seq[i]) begin n_bad++; $display("FAIL b2b_state[%0d]: got %0d want %0d", i, state, seq[i]); end
         n_cmp++;
         if (outs !== exp_outs(seq[i])) begin n_bad++; $display("FAIL b2b_outs[%0d]: got %b want %b", i, outs, exp_outs(seq[i])); end
         if (i < 6 && instr_done === 1'b1) dones++;
         if (i == 2) begin
            n_cmp++;
            if ({alu_op, pc_write_cond} !== 3'b011) begin n_bad++; $display("FAIL beq_ctrl: got %b want 011", {alu_op, pc_write_cond}); end
         end
         if (i == 5) begin
            n_cmp++;
            if ({pc_source, pc_write} !== 3'b101) begin n_bad++; $display("FAIL j_ctrl: got %b want 101", {pc_source, pc_write}); end
         end
      end
      n_cmp++;
      if (dones !== 2) begin n_bad++; $display("FAIL b2b_done_count: got %0d want 2", dones); end
   endtask

   task automatic test_sw_latched();
      logic [3:0] seq [5] = '{4'd1, 4'd2, 4'd3, 4'd6, 4'd1};
      opcode = 6'b101011;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         if (i == 2) opcode = 6'b000100;
         n_cmp++;
         if (state !== seq[i]) begin n_bad++; $display("FAIL sw_state[%0d]: got %0d want %0d", i, state, seq[i]); end
         n_cmp++;
         if (outs !== exp_outs(seq[i])) begin n_bad++; $display("FAIL sw_outs[%0d]: got %b want %b", i, outs, exp_outs(seq[i])); end
         n_cmp++;
         if (mem_read === 1'b1 && mem_write === 1'b1) begin n_bad++; $display("FAIL sw_rw_exclusive[%0d]: got 11 want not both", i); end
      end
   endtask

   task automatic test_addi();
      logic [3:0] seq [5] = '{4'd1, 4'd2, 4'd11, 4'd12, 4'd1};
      opcode = 6'b001000;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         n_cmp++;
         if (state !== seq[i]) begin n_bad++; $display("FAIL addi_state[%0d]: got %0d want %0d", i, state, seq[i]); end
         n_cmp++;
         if (outs !== exp_outs(seq[i])) begin n_bad++; $display("FAIL addi_outs[%0d]: got %b want %b", i, outs, exp_outs(seq[i])); end
      end
   endtask

   task automatic test_reset_mid_rexec();
      opcode = 6'b000000;
      @(negedge clk);
      @(negedge clk);
      n_cmp++;
      if (state !== 4'd7) begin n_bad++; $display("FAIL mid_pre_state: got %0d want 7", state); end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if (state !== 4'd0) begin n_bad++; $display("FAIL mid_reset_state: got %0d want 0", state); end
      n_cmp++;
      if (outs !== 18'd0) begin n_bad++; $display("FAIL mid_reset_outs: got %b want all 0", outs); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (state !== 4'd1) begin n_bad++; $display("FAIL mid_release_state: got %0d want 1", state); end
      n_cmp++;
      if (outs !== exp_outs(4'd1)) begin n_bad++; $display("FAIL mid_release_outs: got %b want %b", outs, exp_outs(4'd1)); end
   endtask

   task automatic test_illegal();
      opcode = 6'b111111;
      @(negedge clk);
      n_cmp++;
      if (state !== 4'd2) begin n_bad++; $display("FAIL ill_decode: got %0d want 2", state); end
      for (int i = 0; i < 22; i++) begin
         @(negedge clk);
         if (i == 3) opcode = 6'b100011;
         n_cmp++;
         if (state !== 4'd13) begin n_bad++; $display("FAIL ill_state[%0d]: got %0d want 13", i, state); end
         n_cmp++;
         if (outs !== exp_outs(4'd13)) begin n_bad++; $display("FAIL ill_outs[%0d]: got %b want %b", i, outs, exp_outs(4'd13)); end
      end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({state, illegal} !== 5'b0) begin n_bad++; $display("FAIL ill_reset: got state %0d illegal %b want 0 0", state, illegal); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (state !== 4'd1) begin n_bad++; $display("FAIL ill_release_state: got %0d want 1", state); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_lw();
      test_rtype();
      test_back_to_back();
      test_sw_latched();
      test_addi();
      test_reset_mid_rexec();
      test_illegal();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
